// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - button-driven 2-bit mux select sequencer (manual step / auto scan)
// Optional MUX_SEL_BIDIR_EN adds a debounced btn_prev that steps the select downwards.
module mux_select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_next,
  input  logic       btn_mode,
`ifdef MUX_SEL_BIDIR_EN
  input  logic       btn_prev,
`endif
  output logic [1:0] sel,
  output logic       sel_strobe,
  output logic       auto_mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

`ifdef MUX_SEL_BIDIR_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] acc_q, acc_d;
  logic [NB-1:0] press_q, press_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          strobe_q;
  logic          next_p, mode_p;

`ifdef MUX_SEL_BIDIR_EN
  logic          prev_p;
  assign btn_raw = {btn_prev, btn_mode, btn_next};
  assign prev_p  = press_q[2];
`else
  assign btn_raw = {btn_mode, btn_next};
`endif

  assign next_p = press_q[0];
  assign mode_p = press_q[1];

  // A counter that has reached the threshold flips the level on the following edge;
  // the press pulse is registered so the FSM acts one edge after acceptance.
  always_comb begin
    acc_d   = acc_q;
    press_d = '0;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = cnt_q[b];
      if (cnt_q[b] == CW'(DEBOUNCE_CYCLES)) begin
        acc_d[b]   = ~acc_q[b];
        cnt_d[b]   = '0;
        press_d[b] = ~acc_q[b];
      end else if (sync2_q[b] != acc_q[b]) begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    case (state_q)
      MANUAL: begin
        if (mode_p) begin
          state_d = AUTO;
          presc_d = '0;
        end else begin
`ifdef MUX_SEL_BIDIR_EN
          if (next_p && !prev_p) begin
            sel_d = sel_q + 2'd1;
          end else if (prev_p && !next_p) begin
            sel_d = sel_q - 2'd1;
          end
`else
          if (next_p) begin
            sel_d = sel_q + 2'd1;
          end
`endif
        end
      end
      AUTO: begin
        if (mode_p) begin
          state_d = MANUAL;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
          presc_d = '0;
          sel_d   = sel_q + 2'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      acc_q    <= '0;
      press_q  <= '0;
      for (int b = 0; b < NB; b++) begin
        cnt_q[b] <= '0;
      end
      state_q  <= MANUAL;
      sel_q    <= 2'd0;
      presc_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= ena && (sel_d != sel_q);
      if (ena) begin
        sync1_q <= btn_raw;
        sync2_q <= sync1_q;
        acc_q   <= acc_d;
        press_q <= press_d;
        for (int b = 0; b < NB; b++) begin
          cnt_q[b] <= cnt_d[b];
        end
        state_q <= state_d;
        sel_q   <= sel_d;
        presc_q <= presc_d;
      end
    end
  end

  assign sel        = sel_q;
  assign sel_strobe = strobe_q & ena;
  assign auto_mode  = (state_q == AUTO);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - randomized bench for mux_select_sequencer against a window-based model
module tb_mux_select_sequencer;
  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_prev = 1'b0;
  logic [1:0] sel;
  logic       sel_strobe;
  logic       auto_mode;

  int total = 0;
  int bad = 0;
  bit cmp_on = 0;

  mux_select_sequencer #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_next   (btn_next),
    .btn_mode   (btn_mode),
`ifdef MUX_SEL_BIDIR_EN
    .btn_prev   (btn_prev),
`endif
    .sel        (sel),
    .sel_strobe (sel_strobe),
    .auto_mode  (auto_mode)
  );

  always #5 clk = ~clk;

  // Model: enabled-edge raw history; a level is accepted once D raw samples,
  // seen through the 2-edge synchroniser, all disagree with it.
  logic [2:0] hist[$];
  bit   [2:0] acc;
  bit   [2:0] press_p;
  int         last_flip [3];
  int         n;
  int         msel;
  bit         mauto;
  int         t_enter;
  bit         mchg;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        acc = '0; press_p = '0; n = 0;
        for (int b = 0; b < 3; b++) last_flip[b] = -1000;
        msel = 0; mauto = 0; t_enter = 0; mchg = 0;
      end else if (!ena) begin
        mchg = 0;
      end else begin
        bit [2:0] np;
        bit       fl;
        int       step;
        mchg = 0;
        if (!mauto) begin
          if (press_p[1]) begin
            mauto = 1; t_enter = n;
          end else begin
            step = int'(press_p[0]);
`ifdef MUX_SEL_BIDIR_EN
            step = step - int'(press_p[2]);
`endif
            if (step != 0) begin
              msel = (msel + step + 4) % 4; mchg = 1;
            end
          end
        end else begin
          if (press_p[1]) mauto = 0;
          else if ((n - t_enter) % S == 0) begin
            msel = (msel + 1) % 4; mchg = 1;
          end
        end
        hist.push_back({btn_prev, btn_mode, btn_next});
        np = '0;
        for (int b = 0; b < 3; b++) begin
          if (n - D - 2 >= 0 && n - D > last_flip[b]) begin
            fl = 1;
            for (int i = n - D - 2; i <= n - 3; i++)
              if (hist[i][b] == acc[b]) fl = 0;
            if (fl) begin
              acc[b] = ~acc[b]; last_flip[b] = n; np[b] = acc[b];
            end
          end
        end
`ifndef MUX_SEL_BIDIR_EN
        np[2] = 1'b0;
`endif
        press_p = np;
        n++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_on) begin
        chk("model_sel", 32'(sel), 32'(msel));
        chk("model_auto", 32'(auto_mode), 32'(mauto));
        chk("model_strobe", 32'(sel_strobe), 32'(mchg && ena));
      end
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_next = v;
      1: btn_mode = v;
      default: btn_prev = v;
    endcase
  endtask

  task automatic pulse_btn(input int b, input int hold, input int rel);
    @(posedge clk); #1 set_btn(b, 1'b1);
    repeat (hold) @(posedge clk);
    #1 set_btn(b, 1'b0);
    repeat (rel) @(posedge clk);
  endtask

  int  dur;
  bit  strobe_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_on = 1;
    @(negedge clk);
    chk("reset_sel", 32'(sel), 0);
    chk("reset_strobe", 32'(sel_strobe), 0);
    chk("reset_auto", 32'(auto_mode), 0);

    // bounce: runs of 2 never reach the threshold of 4
    strobe_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 btn_next = 1'b1;
      @(posedge clk); #1 btn_next = 1'b0;
      if (sel_strobe) strobe_seen = 1;
    end
    repeat (20) begin
      @(negedge clk);
      if (sel_strobe) strobe_seen = 1;
    end
    chk("bounce_sel", 32'(sel), 0);
    chk("bounce_strobe", 32'(strobe_seen), 0);

    // clean press: step lands on edge D+3 = 7
    @(posedge clk); #1 btn_next = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("press_e6_sel", 32'(sel), 0);
    @(posedge clk);
    @(negedge clk);
    chk("press_e7_sel", 32'(sel), 1);
    chk("press_e7_strobe", 32'(sel_strobe), 1);
    @(negedge clk);
    chk("press_e8_strobe", 32'(sel_strobe), 0);
    repeat (3) @(posedge clk);
    #1 btn_next = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("held_one_step", 32'(sel), 1);
    for (int k = 0; k < 3; k++) pulse_btn(0, 12, 12);
    @(negedge clk);
    chk("wrap_to_0", 32'(sel), 0);

    // auto: mode accepted at edge 7, first scan step at edge 15
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (12) @(posedge clk);
    #1 btn_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("auto_on", 32'(auto_mode), 1);
    chk("auto_e14_sel", 32'(sel), 0);
    @(posedge clk);
    @(negedge clk);
    chk("auto_e15_sel", 32'(sel), 1);
    chk("auto_e15_strobe", 32'(sel_strobe), 1);
    pulse_btn(0, 12, 12);
    repeat (5) @(posedge clk);
    #1 ena = 1'b0;
    repeat (20) @(posedge clk);
    #1 ena = 1'b1;
    repeat (10) @(posedge clk);
    pulse_btn(1, 12, 12);
    @(negedge clk);
    chk("auto_off", 32'(auto_mode), 0);

    // random buttons, bounces and enable gaps
    for (int s = 0; s < 200; s++) begin
      @(posedge clk); #1;
      btn_next = ($urandom_range(0, 2) == 0);
      btn_mode = ($urandom_range(0, 7) == 0);
`ifdef MUX_SEL_BIDIR_EN
      btn_prev = ($urandom_range(0, 2) == 0);
`endif
      ena = ($urandom_range(0, 5) != 0);
      dur = $urandom_range(1, 14);
      repeat (dur) @(posedge clk);
    end
    #1;
    btn_next = 1'b0; btn_mode = 1'b0; btn_prev = 1'b0; ena = 1'b1;
    repeat (30) @(posedge clk);

    // reset asserted mid-AUTO, checked between edges
    if (!auto_mode) pulse_btn(1, 12, 12);
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 0);
    chk("async_rst_strobe", 32'(sel_strobe), 0);
    chk("async_rst_auto", 32'(auto_mode), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef MUX_SEL_BIDIR_EN
    pulse_btn(2, 12, 12);
    @(negedge clk);
    chk("prev_wrap_3", 32'(sel), 3);
    @(posedge clk); #1 btn_next = 1'b1; btn_prev = 1'b1;
    repeat (12) @(posedge clk);
    #1 btn_next = 1'b0; btn_prev = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("next_prev_cancel", 32'(sel), 3);
`else
    pulse_btn(0, 12, 12);
    @(negedge clk);
    chk("post_rst_step", 32'(sel), 1);
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
